// File: rtl/dsram_like_resp.sv
// Single-port word memory with a fixed-latency, in-order response pipe in the style of an SRAM-like bus slave.
// Reads sample the word at acceptance; writes merge byte lanes at acceptance.
module dsram_like_resp #(
    parameter int MEM_AW    = 10,
    parameter int LATENCY   = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_en,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        stall_inj,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        resp_wr
);

    localparam int         PW      = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int         CW      = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);
    localparam logic [3:0] POP_AGE = 4'(LATENCY - 1);
    localparam logic [3:0] AGE_MAX = 4'(LATENCY);
    localparam bit         BYPASS  = (LATENCY == 1);

    logic [31:0]       mem [2**MEM_AW];
    logic [MEM_AW-1:0] idx;
    logic [31:0]       rd_word;
    logic              accept;
    logic              push;
    logic              pop_fifo;
    logic              resp_fire;
    logic              resp_wr_d;
    logic [31:0]       resp_data_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic              vld_q  [MAX_OUTST];
    logic [3:0]        age_q  [MAX_OUTST];
    logic              wr_q   [MAX_OUTST];
    logic [31:0]       data_q [MAX_OUTST];
    logic              data_ok_q;
    logic [31:0]       rdata_q;
    logic              resp_wr_q;
    logic              unused_addr_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign idx              = req_addr[MEM_AW+1:2];
    assign unused_addr_bits = ^{req_addr[31:MEM_AW+2], req_addr[1:0]};
    assign rd_word          = mem[idx];

    assign addr_ok = !reset && !stall_inj && (outst_q < MAX_C);
    assign accept  = req_en && addr_ok;

    // Latency 1 answers straight from the accept cycle; deeper latencies go through the FIFO.
    assign push     = accept && !BYPASS;
    assign pop_fifo = !BYPASS && vld_q[rd_ptr_q] && (age_q[rd_ptr_q] == POP_AGE);

    always_comb begin
        resp_fire   = pop_fifo;
        resp_wr_d   = wr_q[rd_ptr_q];
        resp_data_d = data_q[rd_ptr_q];
        if (BYPASS) begin
            resp_fire   = accept;
            resp_wr_d   = (req_we != 4'h0);
            resp_data_d = (req_we != 4'h0) ? 32'h0 : rd_word;
        end
    end

    always_comb begin
        outst_d = outst_q;
        if (accept && !resp_fire) begin
            outst_d = outst_q + 1'b1;
        end else if (!accept && resp_fire) begin
            outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int b = 0; b < 4; b++) begin
                if (req_we[b]) begin
                    mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outst_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            resp_wr_q <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                vld_q[i] <= 1'b0;
                age_q[i] <= '0;
            end
        end else begin
            outst_q   <= outst_d;
            data_ok_q <= resp_fire;
            rdata_q   <= resp_fire ? resp_data_d : 32'h0;
            resp_wr_q <= resp_fire && resp_wr_d;
            for (int i = 0; i < MAX_OUTST; i++) begin
                if (vld_q[i] && (age_q[i] != AGE_MAX)) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
            if (pop_fifo) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= ptr_inc(rd_ptr_q);
            end
            // Age 1 marks the first cycle after acceptance.
            if (push) begin
                vld_q[wr_ptr_q]  <= 1'b1;
                age_q[wr_ptr_q]  <= 4'd1;
                wr_q[wr_ptr_q]   <= (req_we != 4'h0);
                data_q[wr_ptr_q] <= (req_we != 4'h0) ? 32'h0 : rd_word;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
        end
    end

    assign data_ok = data_ok_q && !reset;
    assign rdata   = reset ? 32'h0 : rdata_q;
    assign resp_wr = resp_wr_q && !reset;

endmodule

// File: tb/tb_dsram_like_resp.sv
// Bench for dsram_like_resp: scoreboard against a word-array memory model, plus a LATENCY=8 instance
// for the full-FIFO and reset-drop scenarios.
module tb_dsram_like_resp;

    localparam int LAT  = 2;
    localparam int MAXO = 4;

    typedef struct {
        int          acc;
        int          due;
        bit          wr;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_en = 1'b0;
    logic [3:0]  req_we = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall = 1'b0;
    logic        addr_ok, data_ok, resp_wr;
    logic [31:0] rdata;

    logic        rst8 = 1'b1;
    logic        req_en8 = 1'b0;
    logic [3:0]  req_we8 = 4'hF;
    logic [31:0] req_addr8 = 32'h0;
    logic [31:0] req_wdata8 = 32'h0;
    logic        stall8 = 1'b0;
    logic        addr_ok8, data_ok8, resp_wr8;
    logic [31:0] rdata8;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    resp_t       sbq[$];
    logic [31:0] mm [1024];
    logic [31:0] last_rdata = 32'h0;

    dsram_like_resp #(.MEM_AW(10), .LATENCY(LAT), .MAX_OUTST(MAXO)) u_dut (
        .clk(clk), .reset(rst), .req_en(req_en), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall_inj(stall), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .resp_wr(resp_wr)
    );

    dsram_like_resp #(.MEM_AW(10), .LATENCY(8), .MAX_OUTST(4)) u_l8 (
        .clk(clk), .reset(rst8), .req_en(req_en8), .req_we(req_we8), .req_addr(req_addr8),
        .req_wdata(req_wdata8), .stall_inj(stall8), .addr_ok(addr_ok8), .data_ok(data_ok8),
        .rdata(rdata8), .resp_wr(resp_wr8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Issue side: on every acceptance, record the expected response and apply the store to the model.
    always @(negedge clk) begin
        if (!rst && req_en && addr_ok) begin
            resp_t e;
            logic [9:0] wi;
            wi     = req_addr[11:2];
            e.acc  = cyc;
            e.due  = cyc + LAT;
            e.wr   = (req_we != 4'h0);
            e.data = e.wr ? 32'h0 : mm[wi];
            sbq.push_back(e);
            for (int b = 0; b < 4; b++)
                if (req_we[b]) mm[wi][b*8 +: 8] = req_wdata[b*8 +: 8];
        end
    end

    // Monitor side: addr_ok against pending count, responses against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_addr_ok", addr_ok, 0);
            check("rst_data_ok", data_ok, 0);
            check("rst_rdata", rdata, 0);
            check("rst_resp_wr", resp_wr, 0);
            sbq.delete();
        end else begin
            int pend;
            resp_t e;
            pend = 0;
            foreach (sbq[k]) if (sbq[k].acc < cyc && sbq[k].due > cyc) pend++;
            check("addr_ok", addr_ok, 32'(!stall && pend < MAXO));
            if (data_ok) begin
                if (sbq.size() == 0) begin
                    check("spurious_data_ok", data_ok, 0);
                end else begin
                    e = sbq.pop_front();
                    check("resp_cycle", cyc, e.due);
                    check("resp_wr", resp_wr, e.wr);
                    check("resp_rdata", rdata, e.data);
                    if (!resp_wr) last_rdata = rdata;
                end
            end else begin
                check("idle_rdata", rdata, 0);
                check("idle_resp_wr", resp_wr, 0);
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    check("resp_missing", data_ok, 1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        bit got;
        got       = 1'b0;
        req_en    = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (addr_ok) got = 1'b1;
            @(posedge clk);
            #1;
        end
        req_en = 1'b0;
        check("issue_accepted", got, 1);
    endtask

    initial begin
        int acc_cnt;
        int first_ok;
        int dues[$];
        int pend;
        logic exp_d;

        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        int first_ok;
        int dues[$];
        int pend;
        logic exp_d;

        idle(3);
        rst = 1'b0;
        for (int w = 0; w < 8; w++) issue(4'hF, 32'(w * 4), $urandom);

        // Full write then read of the same word.
        issue(4'hF, 32'h10, 32'hDEADBEEF);
        idle(1);
        issue(4'h0, 32'h10, 32'h0);
        idle(3);
        check("wr_then_rd", last_rdata, 32'hDEADBEEF);

        // Single byte-lane merge.
        issue(4'hF, 32'h10, 32'h11223344);
        issue(4'b0100, 32'h12, 32'h00AB0000);
        issue(4'h0, 32'h10, 32'h0);
        idle(3);
        check("byte_merge", last_rdata, 32'h11AB3344);

        // Back-to-back reads.
        acc_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            req_en = 1'b1; req_we = 4'h0; req_addr = 32'(k * 4);
            @(negedge clk);
            if (addr_ok) acc_cnt++;
            @(posedge clk);
            #1;
        end
        req_en = 1'b0;
        check("b2b_accepts", acc_cnt, 6);
        idle(4);

        // Backpressure holds a write off for three cycles.
        acc_cnt = 0;
        stall = 1'b1; req_en = 1'b1; req_we = 4'hF; req_addr = 32'h18; req_wdata = 32'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (addr_ok) acc_cnt++;
            @(posedge clk);
            #1;
        end
        check("stall_no_accept", acc_cnt, 0);
        stall = 1'b0;
        @(negedge clk);
        check("stall_release_accept", addr_ok, 1);
        @(posedge clk);
        #1;
        req_en = 1'b0;
        issue(4'h0, 32'h18, 32'h0);
        idle(3);
        check("stall_write_read", last_rdata, 32'hCAFEF00D);

        // Random traffic with a reset in the middle.
        for (int i = 0; i < 300; i++) begin
            rst       = (i >= 150 && i < 152);
            req_en    = 1'($urandom_range(0, 1));
            req_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            req_addr  = {20'($urandom), 7'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
            req_wdata = $urandom;
            stall     = ($urandom_range(0, 4) == 0);
            @(posedge clk);
            #1;
        end
        req_en = 1'b0; stall = 1'b0; rst = 1'b0;
        idle(5);
        check("sb_drained", sbq.size(), 0);

        // LATENCY=8: fill to four outstanding, fifth accepted on the first data_ok cycle.
        rst8 = 1'b0;
        req_en8 = 1'b1;
        first_ok = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            pend = 0;
            exp_d = 1'b0;
            foreach (dues[k]) begin
                if (dues[k] - 8 < c && dues[k] > c) pend++;
                if (dues[k] == c) exp_d = 1'b1;
            end
            check("l8_addr_ok", addr_ok8, 32'(pend < 4));
            check("l8_data_ok", data_ok8, exp_d);
            if (data_ok8 && first_ok < 0) begin
                first_ok = c;
                check("l8_accept_on_first_resp", addr_ok8, 1);
            end
            if (req_en8 && addr_ok8) dues.push_back(c + 8);
            @(posedge clk);
            #1;
        end
        check("l8_first_resp_cycle", first_ok, 8);

        // LATENCY=8: reset with three requests in flight drops them.
        req_en8 = 1'b0;
        rst8 = 1'b1;
        idle(2);
        rst8 = 1'b0;
        req_en8 = 1'b1;
        acc_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (addr_ok8) acc_cnt++;
            @(posedge clk);
            #1;
        end
        req_en8 = 1'b0;
        check("l8_inflight_accepts", acc_cnt, 3);
        idle(1);
        rst8 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("l8_rst_addr_ok", addr_ok8, 0);
            check("l8_rst_data_ok", data_ok8, 0);
            @(posedge clk);
            #1;
        end
        rst8 = 1'b0;
        @(negedge clk);
        check("l8_addr_ok_after_rst", addr_ok8, 1);
        for (int k = 0; k < 12; k++) begin
            check("l8_no_resp_after_rst", data_ok8, 0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
